// File: rtl/pose_pkg.sv
// Shared types and helpers for the multi-joint pose scorer.
// Angles are unsigned binary fractions of a full circle.
package pose_pkg;

  localparam int ANGLE_DEPTH = 16;
  // Fractional guard bits below the coordinate LSB keep short vectors accurate.
  localparam int CORDIC_FRAC = 8;

  typedef logic [ANGLE_DEPTH-1:0] angle_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    LOAD,
    ITERATE,
    ACCUM,
    DONE
  } state_t;

  // round(atan(2^-i) * 2^aw / (2*pi)), derived from a 32-bit full-scale table
  function automatic logic [31:0] atan_lut(input int i, input int aw);
    logic [31:0] v;
    logic [32:0] r;
    case (i)
      0:  v = 32'h2000_0000;
      1:  v = 32'h12E4_051E;
      2:  v = 32'h09FB_385B;
      3:  v = 32'h0511_11D4;
      4:  v = 32'h028B_0D43;
      5:  v = 32'h0145_D7E1;
      6:  v = 32'h00A2_F61E;
      7:  v = 32'h0051_7C55;
      8:  v = 32'h0028_BE53;
      9:  v = 32'h0014_5F2F;
      10: v = 32'h000A_2F98;
      11: v = 32'h0005_17CC;
      12: v = 32'h0002_8BE6;
      13: v = 32'h0001_45F3;
      14: v = 32'h0000_A2FA;
      15: v = 32'h0000_517D;
      default: v = 32'd683565276 >> i;
    endcase
    if (aw >= 32) return v;
    r = {1'b0, v} + (33'd1 << (31 - aw));
    r = r >> (32 - aw);
    return r[31:0];
  endfunction

  // Shortest distance between two aw-bit angles around the circle
  function automatic logic [31:0] circ_err(input logic [31:0] a, input logic [31:0] b,
                                           input int aw);
    logic [31:0] mask;
    logic [31:0] d;
    mask = (32'd1 << aw) - 32'd1;
    d = (a - b) & mask;
    if (d[aw-1]) d = (~d + 32'd1) & mask;
    return d;
  endfunction

endpackage

// File: rtl/cordic_vec_core.sv
// Iterative vectoring CORDIC: load folds the vector into the right half-plane,
// each step applies one micro-rotation. No backpressure; the controller sequences it.
module cordic_vec_core
  import pose_pkg::*;
#(
  parameter int COORD_DEPTH = 16,
  parameter int ANGLE_DEPTH = 16,
  parameter int ITER        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load,
  input  logic                          step,
  input  logic [$clog2(ITER)-1:0]       iter_idx,
  input  logic signed [COORD_DEPTH-1:0] x_in,
  input  logic signed [COORD_DEPTH-1:0] y_in,
  output logic [ANGLE_DEPTH-1:0]        z
);

  localparam int W = COORD_DEPTH + 2 + CORDIC_FRAC;

  logic signed [W-1:0]    x_q, y_q, x_ld, y_ld, x_sh, y_sh;
  logic                   zero_q;
  logic [ANGLE_DEPTH-1:0] lut;

  always_comb begin
    x_ld = {{(W-COORD_DEPTH-CORDIC_FRAC){x_in[COORD_DEPTH-1]}}, x_in, {CORDIC_FRAC{1'b0}}};
    y_ld = {{(W-COORD_DEPTH-CORDIC_FRAC){y_in[COORD_DEPTH-1]}}, y_in, {CORDIC_FRAC{1'b0}}};
    x_sh = x_q >>> iter_idx;
    y_sh = y_q >>> iter_idx;
    lut  = ANGLE_DEPTH'(atan_lut(int'(iter_idx), ANGLE_DEPTH));
  end

  // A null vector has no direction; its angle is pinned to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z      <= '0;
      zero_q <= 1'b0;
    end else if (load) begin
      zero_q <= (x_in == '0) && (y_in == '0);
      if (x_in[COORD_DEPTH-1]) begin
        x_q <= -x_ld;
        y_q <= -y_ld;
        z   <= {1'b1, {(ANGLE_DEPTH-1){1'b0}}};
      end else begin
        x_q <= x_ld;
        y_q <= y_ld;
        z   <= '0;
      end
    end else if (step && !zero_q) begin
      if (!y_q[W-1]) begin
        x_q <= x_q + y_sh;
        y_q <= y_q - x_sh;
        z   <= z + lut;
      end else begin
        x_q <= x_q - y_sh;
        y_q <= y_q + x_sh;
        z   <= z - lut;
      end
    end
  end

endmodule

// File: rtl/multi_joint_scorer.sv
// Scores SEQ_LEN frames of NUM_JOINTS angles against a reference table; ITER+2 cycles per joint.
// frame_ready only in WAIT_FRAME; optional per-joint weights under JOINT_WEIGHT_EN.
module multi_joint_scorer
  import pose_pkg::*;
#(
  parameter int NUM_JOINTS  = 3,
  parameter int COORD_DEPTH = 16,
  parameter int ANGLE_DEPTH = pose_pkg::ANGLE_DEPTH,
  parameter int ITER        = 16,
  parameter int SEQ_LEN     = 20,
  parameter int SCORE_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              ref_clear,
  input  logic                              fill,
  input  logic [ANGLE_DEPTH-1:0]            refer_in,
  output logic                              ref_full,
  input  logic                              frame_valid,
  output logic                              frame_ready,
  input  logic [NUM_JOINTS*COORD_DEPTH-1:0] x_in,
  input  logic [NUM_JOINTS*COORD_DEPTH-1:0] y_in,
`ifdef JOINT_WEIGHT_EN
  input  logic [NUM_JOINTS*4-1:0]           weight_in,
`endif
  output logic [ANGLE_DEPTH-1:0]            angle_out,
  output logic                              angle_valid,
  output logic [$clog2(NUM_JOINTS)-1:0]     joint_idx,
  output logic                              busy,
  output logic [SCORE_WIDTH-1:0]            score,
  output logic                              done
);

  localparam int DEPTH = SEQ_LEN * NUM_JOINTS;
  localparam int PW    = $clog2(DEPTH + 1);
  localparam int FW    = $clog2(SEQ_LEN);
  localparam int JW    = $clog2(NUM_JOINTS);
  localparam int IW    = $clog2(ITER);

  state_t                        state_q, state_d;
  logic [PW-1:0]                 wptr, rd_idx;
  logic [ANGLE_DEPTH-1:0]        mem [DEPTH];
  logic [FW-1:0]                 frame_q;
  logic [JW-1:0]                 joint_q;
  logic [IW-1:0]                 iter_q;
  logic signed [COORD_DEPTH-1:0] xb [NUM_JOINTS];
  logic signed [COORD_DEPTH-1:0] yb [NUM_JOINTS];
  logic [SCORE_WIDTH-1:0]        acc, acc_nxt;
  logic [SCORE_WIDTH:0]          sum;
  logic [ANGLE_DEPTH-1:0]        z, ref_rd, err;
  logic [ANGLE_DEPTH+3:0]        err_w;
  logic                          wr_en;
`ifdef JOINT_WEIGHT_EN
  logic [3:0]                    weight_q [NUM_JOINTS];
`endif

  assign ref_full = (wptr == PW'(DEPTH));
  assign busy     = (state_q != IDLE);
  assign wr_en    = fill && !ref_clear && !busy && !ref_full;

  cordic_vec_core #(
    .COORD_DEPTH(COORD_DEPTH),
    .ANGLE_DEPTH(ANGLE_DEPTH),
    .ITER       (ITER)
  ) u_cordic (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (state_q == LOAD),
    .step    (state_q == ITERATE),
    .iter_idx(iter_q),
    .x_in    (xb[joint_q]),
    .y_in    (yb[joint_q]),
    .z       (z)
  );

  always_comb begin
    rd_idx = PW'(frame_q) * PW'(NUM_JOINTS) + PW'(joint_q);
    ref_rd = mem[rd_idx];
    err    = ANGLE_DEPTH'(circ_err(32'(z), 32'(ref_rd), ANGLE_DEPTH));
`ifdef JOINT_WEIGHT_EN
    err_w  = {4'b0, err} * {{ANGLE_DEPTH{1'b0}}, weight_q[joint_q]};
`else
    err_w  = {4'b0, err};
`endif
    sum     = {1'b0, acc} + (SCORE_WIDTH+1)'(err_w);
    acc_nxt = sum[SCORE_WIDTH] ? '1 : sum[SCORE_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    frame_ready = 1'b0;
    case (state_q)
      IDLE:       if (start && ref_full) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        frame_ready = 1'b1;
        if (frame_valid) state_d = LOAD;
      end
      LOAD:       state_d = ITERATE;
      ITERATE:    if (iter_q == IW'(ITER - 1)) state_d = ACCUM;
      ACCUM: begin
        if (joint_q != JW'(NUM_JOINTS - 1))   state_d = LOAD;
        else if (frame_q != FW'(SEQ_LEN - 1)) state_d = WAIT_FRAME;
        else                                  state_d = DONE;
      end
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Reference contents survive reset; only the pointer is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[$clog2(DEPTH)-1:0]] <= refer_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr        <= '0;
      frame_q     <= '0;
      joint_q     <= '0;
      iter_q      <= '0;
      acc         <= '0;
      score       <= '0;
      done        <= 1'b0;
      angle_out   <= '0;
      angle_valid <= 1'b0;
      joint_idx   <= '0;
      for (int j = 0; j < NUM_JOINTS; j++) begin
        xb[j] <= '0;
        yb[j] <= '0;
`ifdef JOINT_WEIGHT_EN
        weight_q[j] <= '0;
`endif
      end
    end else begin
      state_q     <= state_d;
      angle_valid <= 1'b0;
      done        <= 1'b0;
      if (ref_clear)  wptr <= '0;
      else if (wr_en) wptr <= wptr + 1'b1;
      case (state_q)
        IDLE: if (start && ref_full) begin
          acc     <= '0;
          frame_q <= '0;
`ifdef JOINT_WEIGHT_EN
          for (int j = 0; j < NUM_JOINTS; j++) weight_q[j] <= weight_in[j*4 +: 4];
`endif
        end
        WAIT_FRAME: if (frame_valid) begin
          joint_q <= '0;
          for (int j = 0; j < NUM_JOINTS; j++) begin
            xb[j] <= x_in[j*COORD_DEPTH +: COORD_DEPTH];
            yb[j] <= y_in[j*COORD_DEPTH +: COORD_DEPTH];
          end
        end
        LOAD:    iter_q <= '0;
        ITERATE: iter_q <= iter_q + 1'b1;
        ACCUM: begin
          angle_out   <= z;
          angle_valid <= 1'b1;
          joint_idx   <= joint_q;
          acc         <= acc_nxt;
          if (joint_q != JW'(NUM_JOINTS - 1)) begin
            joint_q <= joint_q + 1'b1;
          end else begin
            joint_q <= '0;
            if (frame_q != FW'(SEQ_LEN - 1)) frame_q <= frame_q + 1'b1;
          end
        end
        DONE: begin
          score <= acc;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_joint_scorer.sv
// Directed table-driven bench for multi_joint_scorer with a two-frame sequence.
`timescale 1ns/1ps
module tb_multi_joint_scorer;

  localparam int NJ = 3, CD = 16, AD = 16, IT = 16, SL = 2, SW = 32;

  logic               clk = 1'b0;
  logic               rst_n, start, ref_clear, fill, frame_valid;
  logic [AD-1:0]      refer_in;
  logic [NJ*CD-1:0]   x_in, y_in;
  logic               ref_full, frame_ready, angle_valid, busy, done;
  logic [AD-1:0]      angle_out;
  logic [1:0]         joint_idx;
  logic [SW-1:0]      score;
`ifdef JOINT_WEIGHT_EN
  logic [NJ*4-1:0]    weight_in;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  multi_joint_scorer #(
    .NUM_JOINTS(NJ), .COORD_DEPTH(CD), .ANGLE_DEPTH(AD),
    .ITER(IT), .SEQ_LEN(SL), .SCORE_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ref_clear(ref_clear), .fill(fill),
    .refer_in(refer_in), .ref_full(ref_full), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .x_in(x_in), .y_in(y_in),
`ifdef JOINT_WEIGHT_EN
    .weight_in(weight_in),
`endif
    .angle_out(angle_out), .angle_valid(angle_valid), .joint_idx(joint_idx),
    .busy(busy), .score(score), .done(done)
  );

  typedef struct packed {
    logic [NJ-1:0][CD-1:0] x;
    logic [NJ-1:0][CD-1:0] y;
    logic [NJ-1:0][AD-1:0] rf;
    logic [NJ-1:0][AD-1:0] ex;
  } vec_t;

  vec_t tbl [8];
  int   wt [NJ];
  int   checks = 0, failures = 0;

  function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2,
                              input int r0, r1, r2, e0, e1, e2);
    vec_t v;
    v.x[0] = 16'(x0); v.y[0] = 16'(y0);
    v.x[1] = 16'(x1); v.y[1] = 16'(y1);
    v.x[2] = 16'(x2); v.y[2] = 16'(y2);
    v.rf[0] = 16'(r0); v.rf[1] = 16'(r1); v.rf[2] = 16'(r2);
    v.ex[0] = 16'(e0); v.ex[1] = 16'(e1); v.ex[2] = 16'(e2);
    return v;
  endfunction

  function automatic int cerr(input int a, input int b);
    int d;
    d = (a - b) % 65536;
    if (d < 0) d += 65536;
    if (d > 32768) d = 65536 - d;
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_near(input string name, input longint act, input longint exp,
                          input longint tol);
    checks++;
    if (act < exp - tol || act > exp + tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic fill_n(input int n, input int val);
    for (int k = 0; k < n; k++) begin
      fill = 1'b1; refer_in = 16'(val); tick();
    end
    fill = 1'b0;
  endtask

  task automatic load_refs(input int r);
    ref_clear = 1'b1; tick(); ref_clear = 1'b0;
    for (int f = 0; f < SL; f++)
      for (int j = 0; j < NJ; j++) begin
        fill = 1'b1; refer_in = tbl[2*r+f].rf[j]; tick();
      end
    fill = 1'b0;
    chk("ref_full_after_load", ref_full, 1);
  endtask

  task automatic run_seq(input int r, input int hold, input bit timing);
    vec_t v;
    int   acc_exp, tol, t_acc, t_prev, waitc, dcount, atol;
    bit   stall_ok;
    acc_exp = 0; tol = 0; t_prev = 0;
    load_refs(r);
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", busy, 1);
    stall_ok = 1'b1;
    fill = 1'b1; refer_in = 16'h1234;
    for (int c = 0; c < hold; c++) begin
      tick();
      if (!frame_ready || angle_valid || !busy) stall_ok = 1'b0;
    end
    fill = 1'b0;
    if (hold > 0) begin
      chk("stall_without_frame_valid", stall_ok, 1);
      chk("ref_full_fill_while_busy", ref_full, 1);
    end
    for (int f = 0; f < SL; f++) begin
      v = tbl[2*r+f];
      waitc = 0;
      while (!frame_ready && waitc < 200) begin tick(); waitc++; end
      if (waitc >= 200) chk("frame_ready_timeout", 0, 1);
      x_in = v.x; y_in = v.y; frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0; x_in = ~x_in; y_in = ~y_in; t_acc = cyc;
      if (timing && f == 0) chk("frame_ready_low_in_load", frame_ready, 0);
      for (int j = 0; j < NJ; j++) begin
        waitc = 0;
        while (!angle_valid && waitc < 100) begin tick(); waitc++; end
        if (waitc >= 100) chk("angle_valid_timeout", 0, 1);
        else begin
          atol = (v.x[j] == 0 && v.y[j] == 0) ? 0 : 4;
          chk_near($sformatf("angle_r%0d_f%0d_j%0d", r, f, j),
                   cerr(int'(angle_out), int'(v.ex[j])), 0, atol);
          chk("joint_idx", joint_idx, j);
          if (timing && f == 0) chk($sformatf("angle_latency_j%0d", j),
                                    cyc - ((j == 0) ? t_acc : t_prev), 18);
          t_prev = cyc;
          acc_exp += cerr(int'(v.ex[j]), int'(v.rf[j])) * wt[j];
          tol += 4 * wt[j];
        end
        tick();
      end
    end
    waitc = 0;
    while (!done && waitc < 10) begin tick(); waitc++; end
    chk("done_after_last_angle", (waitc <= 2), 1);
    chk_near($sformatf("score_r%0d", r), score, acc_exp, tol);
    chk("busy_at_done", busy, 0);
    dcount = 0;
    for (int c = 0; c < 5; c++) begin tick(); if (done) dcount++; end
    chk("single_done_pulse", dcount, 0);
  endtask

  initial begin
    int waitc;
    bit quiet;
    tbl[0] = mk(100, 0, 0, 100, -100, 0,       0, 0, 0,   0, 16384, 32768);
    tbl[1] = mk(1000, 1000, 0, -100, -1000, -1000, 0, 0, 0, 8192, 49152, 40960);
    tbl[2] = mk(1000, 1, 1000, 1, 1000, 1,      65530, 65530, 65530, 10, 10, 10);
    tbl[3] = mk(1000, -1, 1000, -1, 1000, -1,   65530, 65530, 65530, 65526, 65526, 65526);
    tbl[4] = mk(3000, 4000, -32768, 0, 0, 0,    9672, 32768, 0,   9672, 32768, 0);
    tbl[5] = mk(-5000, 5000, 32767, -32768, 7, -24, 24576, 57344, 52112, 24576, 57344, 52112);
    tbl[6] = mk(10000, 96, 10000, 96, 10000, 96, 0, 0, 0, 100, 100, 100);
    tbl[7] = tbl[6];
    for (int j = 0; j < NJ; j++) wt[j] = 1;
`ifdef JOINT_WEIGHT_EN
    weight_in = 12'h111;
`endif
    rst_n = 1'b0; start = 1'b0; ref_clear = 1'b0; fill = 1'b0; frame_valid = 1'b0;
    refer_in = '0; x_in = '0; y_in = '0;
    #22;
    chk("rst_angle_out", angle_out, 0);
    chk("rst_angle_valid", angle_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_score", score, 0);
    chk("rst_ref_full", ref_full, 0);
    chk("rst_frame_ready", frame_ready, 0);
    rst_n = 1'b1;
    tick();

    ref_clear = 1'b1; tick(); ref_clear = 1'b0;
    fill_n(5, 0);
    chk("ref_full_5_of_6", ref_full, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_ignored_busy", busy, 0);
    chk("start_ignored_ready", frame_ready, 0);
    fill_n(1, 0);
    chk("ref_full_6_of_6", ref_full, 1);

    ref_clear = 1'b1; tick(); ref_clear = 1'b0;
    fill_n(3, 0);
    ref_clear = 1'b1; fill = 1'b1; tick(); ref_clear = 1'b0; fill = 1'b0;
    fill_n(5, 0);
    chk("clear_beats_fill_5", ref_full, 0);
    fill_n(1, 0);
    chk("clear_beats_fill_6", ref_full, 1);

    run_seq(0, 50, 1'b1);
    run_seq(1, 0, 1'b0);

    load_refs(0);
    start = 1'b1; tick(); start = 1'b0;
    waitc = 0;
    while (!frame_ready && waitc < 50) begin tick(); waitc++; end
    x_in = tbl[0].x; y_in = tbl[0].y; frame_valid = 1'b1; tick(); frame_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0; #2;
    chk("midrst_angle_out", angle_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_score", score, 0);
    chk("midrst_ref_full", ref_full, 0);
    chk("midrst_frame_ready", frame_ready, 0);
    chk("midrst_joint_idx", joint_idx, 0);
    tick(); #3; rst_n = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < 60; c++) begin tick(); if (done || angle_valid || busy) quiet = 1'b0; end
    chk("no_activity_after_abort", quiet, 1);

    run_seq(2, 0, 1'b0);

`ifdef JOINT_WEIGHT_EN
    weight_in = 12'h210;
    wt[0] = 0; wt[1] = 1; wt[2] = 2;
    run_seq(3, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_joint_scorer.md
Name: multi_joint_scorer

Overview:
- Multi-channel successor to the single-pair angle/score path.
- Accepts one frame of NUM_JOINTS keypoint vectors per handshake.
- Computes each joint angle with one time-shared iterative vectoring CORDIC.
- Compares each angle against a preloaded reference sequence using circular (wrapped) absolute error, and accumulates a saturating score over SEQ_LEN frames.

Parameters:
- NUM_JOINTS, 3, joint channels per frame
- COORD_DEPTH, 16, signed coordinate width
- ANGLE_DEPTH, 16, unsigned binary angle width; full circle = 2^ANGLE_DEPTH
- ITER, 16, CORDIC iterations (ITER <= ANGLE_DEPTH)
- SEQ_LEN, 20, frames per scored sequence
- SCORE_WIDTH, 32, score accumulator width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  pulse; begin scoring a sequence
- ref_clear  in  1  pulse; reset reference write pointer
- fill  in  1  write refer_in into reference memory
- refer_in  in  ANGLE_DEPTH  reference angle
- ref_full  out  1  reference memory holds SEQ_LEN*NUM_JOINTS entries
- frame_valid  in  1  x_in/y_in hold a frame
- frame_ready  out  1  block accepts a frame
- x_in  in  NUM_JOINTS*COORD_DEPTH  packed signed x; joint j at bits [j*COORD_DEPTH +: COORD_DEPTH]
- y_in  in  NUM_JOINTS*COORD_DEPTH  packed signed y; same packing
- angle_out  out  ANGLE_DEPTH  last computed joint angle
- angle_valid  out  1  one-cycle pulse with angle_out
- joint_idx  out  $clog2(NUM_JOINTS)  joint of angle_out
- busy  out  1  sequence in progress
- score  out  SCORE_WIDTH  final sequence score
- done  out  1  one-cycle pulse; score updated

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0; FSM in IDLE; write pointer 0; accumulator 0. Reset mid-sequence aborts it with no done pulse. Reference contents are not cleared, but ref_full drops to 0.
- Reference load:
  - When !busy && fill, write refer_in to mem[wptr] and increment wptr. Order is frame-major, joint-minor: index = frame*NUM_JOINTS + joint.
  - ref_full = (wptr == SEQ_LEN*NUM_JOINTS). fill is ignored when ref_full or busy.
  - ref_clear sets wptr = 0 and has priority over a simultaneous fill.
- FSM: IDLE, WAIT_FRAME, LOAD, ITERATE, ACCUM, DONE.
- IDLE:
  - start && ref_full -> WAIT_FRAME; accumulator = 0, frame = 0, busy = 1.
  - start with !ref_full is ignored. start while busy is ignored.
- WAIT_FRAME: frame_ready = 1. On frame_valid && frame_ready, capture all x/y into a frame register bank, set joint = 0, go to LOAD.
- LOAD (1 cycle): sign-extend the joint vector to COORD_DEPTH+2 bits.
  - If x < 0: x = -x, y = -y, z = 2^(ANGLE_DEPTH-1).
  - Else: z = 0.
- ITERATE (exactly ITER cycles, i = 0..ITER-1):
  - If y >= 0: x += y>>>i, y -= x>>>i, z += atan_lut[i].
  - Else: the opposite signs.
  - z arithmetic is modulo 2^ANGLE_DEPTH.
- ACCUM (1 cycle):
  - angle_out = z, angle_valid = 1, joint_idx = joint.
  - d = (z - ref) mod 2^A; err = min(d, 2^A - d).
  - Accumulator += err, saturating at 2^SCORE_WIDTH - 1.
  - Next: joint < NUM_JOINTS-1 -> joint++, LOAD. Else frame < SEQ_LEN-1 -> frame++, WAIT_FRAME. Else -> DONE.
- DONE (1 cycle): score = accumulator, done = 1, busy = 0, next state IDLE. score holds until the next DONE.
- Latency: ITER+2 cycles per joint. From frame accept to last angle_valid: NUM_JOINTS*(ITER+2) cycles.
- Boundary cases:
  - x = y = 0 gives angle 0.
  - x = -2^(COORD_DEPTH-1) must not overflow; the internal width covers it.
  - frame_valid outside WAIT_FRAME is not acknowledged.

Optional Feature:
- Macro JOINT_WEIGHT_EN.
- Defined: adds input weight_in [NUM_JOINTS*4], latched at start. In ACCUM, err is multiplied by weight[joint] before the saturating accumulate; weight 0 masks that joint.
- Undefined: no port; weight is effectively 1.

Decomposition:
- Package pose_pkg holds:
  - the state enum;
  - an angle_t typedef;
  - an atan_lut constant function returning round(atan(2^-i) * 2^ANGLE_DEPTH / (2*pi));
  - a circular-error function.
- Sub-module cordic_vec_core: the iterative datapath with load/step controls. The parent instantiates it once.

Test Plan (ANGLE_DEPTH=16, NUM_JOINTS=3, SEQ_LEN=2):
- Unit vectors, refs all 0. Joints (100,0), (0,100), (-100,0) -> angles 0, 16384, 32768 ±4 LSB; angle_valid pulses 18 cycles apart.
- Wrap error. ref=65530, vector (1000,1) -> err ≈ 16, not ≈ 65520. Score reflects the wrapped minimum.
- Full sequence. Two frames, refs equal to the true angles -> done once after the 6th angle_valid; score <= 6*4.
- Guard conditions:
  - start with 5 of 6 refs loaded -> ignored, busy stays 0.
  - fill while busy -> wptr unchanged.
  - ref_clear and fill in the same cycle -> wptr = 0.
- Backpressure and reset. Hold frame_valid low for 50 cycles in WAIT_FRAME -> no progress. Assert rst_n low in ITERATE -> all outputs 0; a new start succeeds after reload.
- JOINT_WEIGHT_EN. Weights {0,1,2} with a constant err of 100 per joint -> score 600 over 2 frames.
